// File: rtl/bcd_updown_ctr_if.sv
// Control/data bundle for the multi-digit BCD up/down counter.
// The master drives count/load controls and reads back count and status.
interface bcd_updown_ctr_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic                  wrap;
  logic                  load_err;

  modport master (
    output en, up, load, d,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, d,
    output q, tc, wrap, load_err
  );
endinterface

// File: rtl/bcd_updown_ctr.sv
// Multi-digit BCD (decade) up/down counter with parallel load and
// cascade output. Digit 0 is the least significant nibble. The carry
// (or borrow) ripples through every digit within a single cycle, so
// q always steps by exactly one decimal count.
module bcd_updown_ctr #(
  parameter int DIGITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  bcd_updown_ctr_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]      q_reg, q_next;
  logic [W-1:0]      count_val;
  logic [W-1:0]      load_val;
  logic              wrap_reg, wrap_next;
  logic              load_err_reg, load_err_next;
  logic [DIGITS-1:0] dig_max;
  logic [DIGITS-1:0] dig_min;
  logic [DIGITS-1:0] clamp;
  logic [DIGITS:0]   carry;

  // Per-digit decode: at-9 / at-0 flags, the stepped digit value and the
  // clamped load digit. Nibbles A-F on d are saturated to 9 so q never
  // holds a non-decimal digit.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] ld;
      assign cur          = q_reg[4*gi +: 4];
      assign ld           = bus.d[4*gi +: 4];
      assign dig_max[gi]  = (cur == 4'd9);
      assign dig_min[gi]  = (cur == 4'd0);
      assign clamp[gi]    = (ld > 4'd9);
      assign load_val[4*gi +: 4] = clamp[gi] ? 4'd9 : ld;
      assign count_val[4*gi +: 4] =
          !carry[gi] ? cur :
          bus.up     ? (dig_max[gi] ? 4'd0 : cur + 4'd1) :
                       (dig_min[gi] ? 4'd9 : cur - 4'd1);
    end
  endgenerate

  // Carry/borrow chain: digit i steps only when every lower digit rolls over.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      carry[i+1] = carry[i] & (bus.up ? dig_max[i] : dig_min[i]);
    end
  end

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    q_next        = q_reg;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (bus.load) begin
      q_next        = load_val;
      load_err_next = |clamp;
    end else if (bus.en) begin
      q_next    = count_val;
      wrap_next = carry[DIGITS];
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg        <= '0;
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      wrap_reg     <= wrap_next;
      load_err_reg <= load_err_next;
    end
  end

  // Terminal count is combinational so a downstream stage steps on the
  // same edge this stage rolls over.
  assign bus.tc       = bus.en & ~bus.load & carry[DIGITS];
  assign bus.q        = q_reg;
  assign bus.wrap     = wrap_reg;
  assign bus.load_err = load_err_reg;
endmodule

// File: tb/tb_bcd_updown_ctr.sv
// Bench for bcd_updown_ctr: directed steps followed by random traffic,
// checked against a decimal-integer reference model. Also checks two
// single-digit stages cascaded through tc against the same model.
module tb_bcd_updown_ctr;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  int   mv;      // reference count as a plain integer 0..99
  bit   mwrap;
  bit   merr;
  bit   casc_on;

  bcd_updown_ctr_if #(.DIGITS(2)) ifm ();
  bcd_updown_ctr_if #(.DIGITS(1)) ifc0 ();
  bcd_updown_ctr_if #(.DIGITS(1)) ifc1 ();

  assign ifc1.en = ifc0.tc;

  bcd_updown_ctr #(.DIGITS(2)) dut (.clk(clk), .rst(rst), .bus(ifm));
  bcd_updown_ctr #(.DIGITS(1)) c0  (.clk(clk), .rst(rst), .bus(ifc0));
  bcd_updown_ctr #(.DIGITS(1)) c1  (.clk(clk), .rst(rst), .bus(ifc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic int clamp9(input int x);
    return (x > 9) ? 9 : x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock transaction: drive, check tc, clock, update model, check outputs.
  task automatic cycle(input bit en, input bit up, input bit ld, input logic [7:0] dv);
    bit exp_tc;
    ifm.en   = en;
    ifm.up   = up;
    ifm.load = ld;
    ifm.d    = dv;
    ifc0.en  = casc_on & en;
    ifc0.up  = up;
    ifc1.up  = up;
    exp_tc   = en && !ld && (up ? (mv == 99) : (mv == 0));
    #1;
    check("tc", ifm.tc, exp_tc);
    @(posedge clk);
    #1;
    if (ld) begin
      mv    = clamp9(int'(dv[7:4])) * 10 + clamp9(int'(dv[3:0]));
      merr  = (dv[7:4] > 4'd9) || (dv[3:0] > 4'd9);
      mwrap = 1'b0;
    end else if (en) begin
      mwrap = up ? (mv == 99) : (mv == 0);
      mv    = up ? (mv + 1) % 100 : (mv + 99) % 100;
      merr  = 1'b0;
    end else begin
      mwrap = 1'b0;
      merr  = 1'b0;
    end
    cyc++;
    check("q", ifm.q, to_bcd(mv));
    check("wrap", ifm.wrap, mwrap);
    check("load_err", ifm.load_err, merr);
    if (casc_on) check("cascade_q", {ifc1.q, ifc0.q}, to_bcd(mv));
    $display("cyc=%0d en=%0b up=%0b load=%0b d=%02h q=%02h wrap=%0b load_err=%0b",
             cyc, en, up, ld, dv, ifm.q, ifm.wrap, ifm.load_err);
  endtask

  // Assert reset between edges, verify immediate clear, release mid-cycle.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    mv = 0; mwrap = 1'b0; merr = 1'b0;
    check("rst_q", ifm.q, 8'h00);
    check("rst_wrap", ifm.wrap, 1'b0);
    check("rst_load_err", ifm.load_err, 1'b0);
    check("rst_casc_q", {ifc1.q, ifc0.q}, 8'h00);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    ifm.en = 1'b0; ifm.up = 1'b0; ifm.load = 1'b0; ifm.d = '0;
    ifc0.en = 1'b0; ifc0.up = 1'b0; ifc0.load = 1'b0; ifc0.d = '0;
    ifc1.up = 1'b0; ifc1.load = 1'b0; ifc1.d = '0;
    casc_on = 1'b0;
    mv = 0; mwrap = 1'b0; merr = 1'b0;

    // Reset state, including tc following q=0 while in reset
    #2;
    check("reset_q", ifm.q, 8'h00);
    check("reset_wrap", ifm.wrap, 1'b0);
    check("reset_load_err", ifm.load_err, 1'b0);
    check("reset_tc_idle", ifm.tc, 1'b0);
    ifm.en = 1'b1;
    ifm.up = 1'b0;
    #1;
    check("reset_tc_down", ifm.tc, 1'b1);
    ifm.up = 1'b1;
    #1;
    check("reset_tc_up", ifm.tc, 1'b0);
    ifm.en = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Count up through the full range and wrap
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    // Count down from 00 through wrap to 89
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Load overrides enable; clamped load flags an error
    cycle(1'b1, 1'b1, 1'b1, 8'h47);
    cycle(1'b0, 1'b1, 1'b1, 8'h3C);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 8'hFA);

    // Hold, then direction changes
    cycle(1'b0, 1'b1, 1'b1, 8'h19);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Async reset mid-count with load_err pending
    cycle(1'b0, 1'b1, 1'b1, 8'h50);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h5F);
    async_reset();
    cycle(1'b1, 1'b1, 1'b0, 8'h00);

    // Async reset with wrap pending
    cycle(1'b0, 1'b1, 1'b1, 8'h99);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 4) != 0, 1'($urandom), ($urandom % 8) == 0, 8'($urandom));
    end

    // Cascade of two single-digit stages against the model
    async_reset();
    casc_on = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom % 4) != 0, (i < 120) ? 1'b1 : 1'($urandom), 1'b0, 8'h00);
    end
    casc_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_updown_ctr.md
# bcd_updown_ctr

Parametrised multi-digit BCD (decade) counter with count enable, up/down direction, synchronous parallel load and cascade outputs. It is the next-generation decade counter: it generalises the single-digit 0-9 counter to DIGITS decade stages. It feeds display/timebase logic and can be chained with further instances through `tc`.

## Interface
- `DIGITS`, default 2: number of BCD decades; legal range 1-8.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  count enable; counts one step per clock while high.
- `up`  input  1  direction: 1 = increment, 0 = decrement; sampled only on counting cycles.
- `load`  input  1  synchronous parallel load; overrides `en`.
- `d`  input  4*DIGITS  load value, digit i in d[4i+3:4i], digit 0 = least significant.
- `q`  output  4*DIGITS  registered count, same digit packing as `d`.
- `tc`  output  1  combinational terminal count: `en` & !`load` & (`up` ? all digits 9 : all digits 0).
- `wrap`  output  1  registered; one-cycle pulse on the cycle after a wrap-around.
- `load_err`  output  1  registered; one-cycle pulse on the cycle after a load containing any digit >9.

## Operation
- Reset: while `rst`=0, `q`=0 (all digits), `wrap`=0, `load_err`=0, independent of `clk`. Reset asserted mid-count aborts immediately. On release, the first rising edge with `rst`=1 operates normally.
- Priority per edge: `load` > `en` > hold.
- Load: each digit of `q` takes the matching digit of `d`. Any digit >9 (A-F) is stored as 9. `load_err` is pulsed if any digit was clamped. `wrap` is 0 on a load cycle.
- Count up: digit 0 increments. A digit at 9 returns to 0 and carries into the next digit. Carry ripples combinationally through all digits within one cycle.
- Count down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
- Wrap-around: up from all-9s gives all-0s; down from all-0s gives all-9s. Either case sets `wrap`=1 for the following cycle.
- Hold (`en`=0, `load`=0): `q` unchanged; `wrap`=0; `load_err`=0.
- Direction change: `up` takes effect on the same edge it is sampled. No pipeline state exists, so there is no extra latency.
- Invalid state: `q` can never hold a digit >9 through reset, count or load.
- Cascade: `tc` of stage N drives `en` of stage N+1, both on the same `clk`. Stage N+1 steps on the same edge that stage N wraps.

## Timing
- `q` updates on the clock edge that samples `en`/`load`. Latency is 1 cycle from input to `q`.
- `wrap` and `load_err` are asserted for exactly one cycle, aligned with the new `q` value.
- `tc` is a purely combinational function of `q`, `en`, `load` and `up`, valid in the same cycle. It has no reset value of its own: it follows `q`=0, so `tc` = `en` & !`load` & !`up` during reset.
- Single clock domain. All of `en`, `up`, `load` and `d` must meet setup/hold to `clk`.
- Critical path is the digit carry chain. It grows linearly with DIGITS and must close at the target clock for DIGITS=8.

## Test plan
- Reset then count up, DIGITS=2, `en`=1, `up`=1 for 100 cycles -> `q` runs 00,01..09,10..99,00. `wrap`=1 only on the cycle `q` shows 00 after 99. `tc`=1 only while `q`=99.
- Count down from 00, `up`=0 -> `q` goes 99,98..90,89. `wrap`=1 on the cycle `q` first shows 99. `tc`=1 while `q`=00 with `en`=1.
- Load `d`=8'h47 with `en`=1 at the same time -> next `q`=47, no count step, `wrap`=0, `load_err`=0. Load `d`=8'h3C -> `q`=39 and `load_err`=1 for one cycle.
- Hold and direction change: at `q`=19, `en`=0 for 3 cycles -> `q` stays 19. Then `en`=1, `up`=1 for one edge -> 20. Then `up`=0 for one edge -> 19. Then 18.
- Async reset mid-operation: count to 57, drop `rst` between clock edges -> `q`=00 and `wrap`/`load_err`=0 immediately, before the next edge. Release -> counting resumes from 00 on the first edge.
- Cascade: two DIGITS=1 instances chained through `tc`, counting up from 00 -> combined count matches a single DIGITS=2 instance cycle-for-cycle over 200 cycles.
